// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_t          : fetch FSM state encoding
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP              : instruction word used for cleared instruction registers
//   pc_plus4         : 32-bit wrapping sequential-address helper
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // one cycle after reset release, no request
    ST_FETCH = 2'd1,  // request outstanding, response is accepted
    ST_HOLD  = 2'd2,  // word parked because decode was stalled
    ST_DROP  = 2'd3   // request outstanding, response will be thrown away
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // Address arithmetic wraps modulo 2^32; the carry out is dropped on purpose.
  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage.
//
// Issues one word-aligned request at a time to instruction memory and hands
// the returned word to decode together with the address of the following
// instruction.
//
// Handshake: imem_req/imem_addr describe the single outstanding request and
// stay constant until imem_valid is seen on a rising edge (same cycle or any
// later cycle). Decode takes the word on any edge where id_valid=1 and
// id_stall=0; while id_valid=1 and id_stall=1 the id_* outputs are frozen.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   imem_req, imem_addr : fetch request and its address (== req_addr)
//   imem_rdata          : instruction word, valid with imem_valid
//   imem_valid          : response strobe for the outstanding request
//   redirect            : taken branch/jump, flush and refetch
//   redirect_pc         : new fetch address, sampled with redirect
//   id_stall            : decode cannot accept a new instruction
//   id_valid            : decode-stage instruction valid
//   id_inst             : registered instruction
//   id_pc4              : address of the instruction + 4
//   id_imm16            : id_inst[15:0], combinational, for the sign extender
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm16
);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        id_valid_nxt;
  logic [31:0] id_inst_nxt, id_pc4_nxt;
  logic [31:0] hold_inst, hold_inst_nxt;
  logic [31:0] hold_pc4, hold_pc4_nxt;
  logic [31:0] resp_pc4;

  assign resp_pc4  = pc_plus4(req_addr);
  assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr = req_addr;
  assign id_imm16  = id_inst[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      id_valid  <= 1'b0;
      id_inst   <= NOP;
      id_pc4    <= 32'd0;
      hold_inst <= NOP;
      hold_pc4  <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      id_valid  <= id_valid_nxt;
      id_inst   <= id_inst_nxt;
      id_pc4    <= id_pc4_nxt;
      hold_inst <= hold_inst_nxt;
      hold_pc4  <= hold_pc4_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    // A valid word that decode takes this edge is consumed unless replaced.
    id_valid_nxt  = id_valid && id_stall;
    id_inst_nxt   = id_inst;
    id_pc4_nxt    = id_pc4;
    hold_inst_nxt = hold_inst;
    hold_pc4_nxt  = hold_pc4;

    case (state)
      ST_IDLE: begin
        // Any stray imem_valid here belongs to a request abandoned by reset.
        state_nxt = ST_FETCH;
        if (redirect) begin
          pc_nxt       = redirect_pc;
          req_addr_nxt = redirect_pc;
        end else begin
          req_addr_nxt = pc;
        end
      end

      ST_FETCH: begin
        if (redirect) begin
          id_valid_nxt  = 1'b0;
          pc_nxt        = redirect_pc;
          hold_inst_nxt = NOP;
          hold_pc4_nxt  = 32'd0;
          if (imem_valid) begin
            // Response retires the old request; start the new one at once.
            req_addr_nxt = redirect_pc;
          end else begin
            // Old request still in flight: keep it on the bus and drop its data.
            state_nxt = ST_DROP;
          end
        end else if (imem_valid) begin
          pc_nxt = resp_pc4;
          if (id_valid && id_stall) begin
            hold_inst_nxt = imem_rdata;
            hold_pc4_nxt  = resp_pc4;
            state_nxt     = ST_HOLD;
          end else begin
            id_valid_nxt = 1'b1;
            id_inst_nxt  = imem_rdata;
            id_pc4_nxt   = resp_pc4;
            req_addr_nxt = resp_pc4;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          id_valid_nxt  = 1'b0;
          pc_nxt        = redirect_pc;
          req_addr_nxt  = redirect_pc;
          hold_inst_nxt = NOP;
          hold_pc4_nxt  = 32'd0;
          state_nxt     = ST_FETCH;
        end else if (!id_stall) begin
          id_valid_nxt  = 1'b1;
          id_inst_nxt   = hold_inst;
          id_pc4_nxt    = hold_pc4;
          hold_inst_nxt = NOP;
          hold_pc4_nxt  = 32'd0;
          req_addr_nxt  = pc;
          state_nxt     = ST_FETCH;
        end
      end

      ST_DROP: begin
        if (redirect) begin
          id_valid_nxt  = 1'b0;
          pc_nxt        = redirect_pc;
          hold_inst_nxt = NOP;
          hold_pc4_nxt  = 32'd0;
        end
        if (imem_valid) begin
          // The discarded response frees the bus for the redirected fetch.
          state_nxt    = ST_FETCH;
          req_addr_nxt = redirect ? redirect_pc : pc;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
